counter_checker: RTL and testbench

//  Receive-side checker for the free-running counter bus (ck/res/q). Samples q

---
 rtl/counter_checker.sv | 112 +++++++++++
 tb/tb_counter_checker.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
// Receive-side monitor for a free-running counter bus: locks onto a clean
// +1 sequence, then pulses err on breaks and wrap on max->0 rollovers.
module counter_checker #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned LOCK_CNT = 2,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             ck,
   input  logic             res,
   input  logic             en,
   input  logic [WIDTH-1:0] q,
   input  logic             clr,
   output logic             locked,
   output logic             err,
   output logic             wrap,
   output logic [ERR_W-1:0] err_cnt
);

   // good must be able to hold LOCK_CNT itself
   localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACQ  = 2'd1;
   localparam logic [1:0] LOCK = 2'd2;

   logic [1:0]        state, state_n;
   logic [WIDTH-1:0]  prev, prev_n;
   logic [GOOD_W-1:0] good, good_n;
   logic              locked_n, err_n, wrap_n;
   logic [ERR_W-1:0]  err_cnt_n;

   logic              inc_ok;
   logic [GOOD_W-1:0] good_inc;

   assign inc_ok   = (q == WIDTH'(prev + 1'b1));
   assign good_inc = GOOD_W'(good + 1'b1);

   // Next-state and next-output logic; en=0 freezes everything except clr
   always_comb begin
      state_n   = state;
      prev_n    = prev;
      good_n    = good;
      err_n     = 1'b0;
      wrap_n    = 1'b0;
      err_cnt_n = err_cnt;

      if (en) begin
         prev_n = q;
         case (state)
            IDLE: begin
               good_n  = '0;
               state_n = ACQ;
            end
            ACQ: begin
               if (inc_ok) begin
                  good_n = good_inc;
                  if (good_inc == GOOD_W'(LOCK_CNT)) begin
                     state_n = LOCK;
                  end
               end else begin
                  good_n = '0;
               end
            end
            LOCK: begin
               if (inc_ok) begin
                  wrap_n = (prev == {WIDTH{1'b1}});
               end else begin
                  err_n   = 1'b1;
                  good_n  = '0;
                  state_n = ACQ;
                  if (err_cnt != {ERR_W{1'b1}}) begin
                     err_cnt_n = ERR_W'(err_cnt + 1'b1);
                  end
               end
            end
            default: begin
               good_n  = '0;
               state_n = IDLE;
            end
         endcase
      end

      // A clear coinciding with a new error still records that error
      if (clr) begin
         err_cnt_n = ERR_W'(err_n);
      end

      locked_n = (state_n == LOCK);
   end

   // State and output registers
   always_ff @(posedge ck or negedge res) begin
      if (!res) begin
         state   <= IDLE;
         prev    <= '0;
         good    <= '0;
         locked  <= 1'b0;
         err     <= 1'b0;
         wrap    <= 1'b0;
         err_cnt <= '0;
      end else begin
         state   <= state_n;
         prev    <= prev_n;
         good    <= good_n;
         locked  <= locked_n;
         err     <= err_n;
         wrap    <= wrap_n;
         err_cnt <= err_cnt_n;
      end
   end

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker: hand-derived expectations are
// queued as each cycle's stimulus is driven and compared after the edge.
module tb_counter_checker;

   localparam int unsigned WIDTH = 4;

   logic             ck;
   logic             res;
   logic             en;
   logic [WIDTH-1:0] q;
   logic             clr;
   logic             locked, err, wrap;
   logic [7:0]       err_cnt;
   logic             locked2, err2, wrap2;
   logic [1:0]       err_cnt2;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string tag;
      logic  l;
      logic  e;
      logic  w;
      int    c;
      int    c2;
   } exp_t;

   exp_t sb[$];

   counter_checker #(.WIDTH(WIDTH), .LOCK_CNT(2), .ERR_W(8)) dut (
      .ck(ck), .res(res), .en(en), .q(q), .clr(clr),
      .locked(locked), .err(err), .wrap(wrap), .err_cnt(err_cnt)
   );

   counter_checker #(.WIDTH(WIDTH), .LOCK_CNT(2), .ERR_W(2)) dut_w2 (
      .ck(ck), .res(res), .en(en), .q(q), .clr(clr),
      .locked(locked2), .err(err2), .wrap(wrap2), .err_cnt(err_cnt2)
   );

   // 8-unit clock period; reset held for 10 units (1.25 periods)
   initial begin
      ck = 1'b0;
      forever #4 ck = ~ck;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   // Drive one cycle, queue its expectation, compare after the edge
   task automatic drive(input string tag, input logic e, input logic [WIDTH-1:0] qv,
                        input logic c, input logic xl, input logic xe, input logic xw,
                        input int xc, input int xc2);
      exp_t x;
      exp_t got;
      x.tag = tag; x.l = xl; x.e = xe; x.w = xw; x.c = xc; x.c2 = xc2;
      sb.push_back(x);
      en  = e;
      q   = qv;
      clr = c;
      @(posedge ck);
      #1;
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 0, 1);
      end else begin
         got = sb.pop_front();
         check({got.tag, ".locked"},   int'(locked),   int'(got.l));
         check({got.tag, ".err"},      int'(err),      int'(got.e));
         check({got.tag, ".wrap"},     int'(wrap),     int'(got.w));
         check({got.tag, ".err_cnt"},  int'(err_cnt),  got.c);
         check({got.tag, ".err_cnt2"}, int'(err_cnt2), got.c2);
      end
   endtask

   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] qb;

   initial begin
      res = 1'b0;
      en  = 1'b0;
      q   = '0;
      clr = 1'b0;
      #2;
      check("reset.locked",   int'(locked),   0);
      check("reset.err",      int'(err),      0);
      check("reset.wrap",     int'(wrap),     0);
      check("reset.err_cnt",  int'(err_cnt),  0);
      check("reset.err_cnt2", int'(err_cnt2), 0);
      #8;
      res = 1'b1;

      // Acquire from a clean 0,1,2,3 sequence
      drive("t1_q0", 1, 4'd0, 0, 0, 0, 0, 0, 0);
      drive("t1_q1", 1, 4'd1, 0, 0, 0, 0, 0, 0);
      drive("t1_q2", 1, 4'd2, 0, 1, 0, 0, 0, 0);
      drive("t1_q3", 1, 4'd3, 0, 1, 0, 0, 0, 0);

      // Run up to max and roll over
      for (int i = 4; i <= 15; i++) drive("t2_run", 1, WIDTH'(i), 0, 1, 0, 0, 0, 0);
      drive("t2_wrap", 1, 4'd0, 0, 1, 0, 1, 0, 0);
      drive("t2_post", 1, 4'd1, 0, 1, 0, 0, 0, 0);

      // Skip from 5 to 7, then relock on 8,9
      for (int i = 2; i <= 5; i++) drive("t3_run", 1, WIDTH'(i), 0, 1, 0, 0, 0, 0);
      drive("t3_skip", 1, 4'd7, 0, 0, 1, 0, 1, 1);
      drive("t3_q8",   1, 4'd8, 0, 0, 0, 0, 1, 1);
      drive("t3_q9",   1, 4'd9, 0, 1, 0, 0, 1, 1);

      // en low with garbage on q holds everything
      for (int i = 0; i < 3; i++) drive("t4_hold", 0, 4'd2, 0, 1, 0, 0, 1, 1);
      drive("t4_q10", 1, 4'd10, 0, 1, 0, 0, 1, 1);

      // clr works with en low; then five break/relock rounds
      drive("t5_clr_en0", 0, 4'd0, 1, 1, 0, 0, 0, 0);
      p = 4'd10;
      for (int i = 1; i <= 5; i++) begin
         qb = WIDTH'(p + 4'd2);
         drive("t5_break", 1, qb, 0, 0, 1, 0, i, (i > 3) ? 3 : i);
         drive("t5_acq",   1, WIDTH'(qb + 4'd1), 0, 0, 0, 0, i, (i > 3) ? 3 : i);
         drive("t5_lock",  1, WIDTH'(qb + 4'd2), 0, 1, 0, 0, i, (i > 3) ? 3 : i);
         p = WIDTH'(qb + 4'd2);
      end
      check("t5_prev_track", int'(p), 14);
      drive("t5_clr_err",   1, 4'd0, 1, 0, 1, 0, 1, 1);
      drive("t5_clr_alone", 1, 4'd1, 1, 0, 0, 0, 0, 0);
      drive("t5_relock",    1, 4'd2, 0, 1, 0, 0, 0, 0);

      // Repeated value is a break
      drive("rep_same", 1, 4'd2, 0, 0, 1, 0, 1, 1);
      drive("rep_q3",   1, 4'd3, 0, 0, 0, 0, 1, 1);
      drive("rep_q4",   1, 4'd4, 0, 1, 0, 0, 1, 1);
      for (int i = 5; i <= 15; i++) drive("t6_run", 1, WIDTH'(i), 0, 1, 0, 0, 1, 1);
      drive("t6_wrap", 1, 4'd0, 0, 1, 0, 1, 1, 1);

      // Async reset between edges clears outputs without a clock
      #2;
      res = 1'b0;
      #1;
      check("t6_rst.locked",   int'(locked),   0);
      check("t6_rst.err_cnt",  int'(err_cnt),  0);
      check("t6_rst.err_cnt2", int'(err_cnt2), 0);
      check("t6_rst.wrap",     int'(wrap),     0);
      check("t6_rst.err",      int'(err),      0);
      #2;
      res = 1'b1;
      drive("t6_q0", 1, 4'd0, 0, 0, 0, 0, 0, 0);
      drive("t6_q1", 1, 4'd1, 0, 0, 0, 0, 0, 0);
      drive("t6_q2", 1, 4'd2, 0, 1, 0, 0, 0, 0);
      drive("t6_q3", 1, 4'd3, 0, 1, 0, 0, 0, 0);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
